// File: rtl/r4_sdf_stage_ctrl_pkg.sv
// Shared types and constants for the radix-4 SDF stage controller.
// FSM encoding, default geometry and group-size helper.
package r4_sdf_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDrain
    } state_t;

    localparam int unsigned QLEN  = 64;
    localparam int unsigned FRAME = 2048 / (4 * QLEN);

    // Samples per group of four quarters.
    function automatic int unsigned group_len(input int unsigned depth);
        return 4 * depth;
    endfunction

endpackage

// File: rtl/r4_tw_addr_gen.sv
// Twiddle ROM address for one stage output: branch * idx * stride, wrapping at 2^AW.
module r4_tw_addr_gen #(
    parameter int unsigned IW        = 6,
    parameter int unsigned AW        = 12,
    parameter int unsigned TW_STRIDE = 4
) (
    input  logic [1:0]    branch,
    input  logic [IW-1:0] idx,
    output logic [AW-1:0] tw_addr
);

    // Truncating every operand to AW bits keeps the product exact modulo 2^AW.
    assign tw_addr = AW'(branch) * AW'(idx) * AW'(TW_STRIDE);

endmodule

// File: rtl/r4_sdf_stage_ctrl.sv
// Radix-4 single-path delay-feedback stage controller: sequences delay-line writes,
// butterfly strobes and branch outputs over IDLE/FILL/RUN/DRAIN; all outputs registered.
module r4_sdf_stage_ctrl
    import r4_sdf_stage_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = QLEN,
    parameter int unsigned N         = 4 * QLEN * FRAME,
    parameter int unsigned TW_STRIDE = 4,
    parameter int unsigned AW        = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic                     bf_en,
    output logic [1:0]               phase,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     out_valid,
    output logic [1:0]               out_branch,
    output logic [AW-1:0]            tw_addr,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned GRP = group_len(DEPTH);
    localparam logic [CW-1:0] FILL_LAST = CW'(3 * DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          accept, step, first_grp;
    logic [1:0]    cur_phase, cur_branch;
    logic [IW-1:0] cur_idx;
    logic [AW-1:0] cur_tw;
    logic          wr_en_d, bf_en_d, out_valid_d, frame_done_d;

    // The sample counter's low bits are the delay-line index and the quarter.
    assign accept     = in_valid && in_ready;
    assign step       = accept || (state_q == StDrain);
    assign cnt_inc    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    assign cur_idx    = cnt_q[IW-1:0];
    assign cur_phase  = cnt_q[IW+1:IW];
    assign cur_branch = (cur_phase == 2'd3) ? 2'd0 : cur_phase + 2'd1;
    assign first_grp  = 32'(cnt_q) < GRP;

    r4_tw_addr_gen #(
        .IW        (IW),
        .AW        (AW),
        .TW_STRIDE (TW_STRIDE)
    ) u_tw_addr_gen (
        .branch  (cur_branch),
        .idx     (cur_idx),
        .tw_addr (cur_tw)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = step ? cnt_inc : cnt_q;
        case (state_q)
            StIdle:  if (accept) state_d = StFill;
            StFill:  if (accept && cnt_q == FILL_LAST) state_d = StRun;
            StRun:   if (cnt_q == '0 && !in_valid) state_d = StDrain;
            StDrain: if (cnt_q == FILL_LAST) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
        if (state_d == StIdle) cnt_d = '0;
    end

    always_comb begin
        wr_en_d      = 1'b0;
        bf_en_d      = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (!flush) begin
            wr_en_d     = accept && (cur_phase != 2'd3);
            bf_en_d     = accept && (state_q == StRun) && (cur_phase == 2'd3);
            out_valid_d = (accept && state_q == StRun) || (state_q == StDrain);
            // A frame's last group emits its branch-3 outputs during the next frame's
            // first group, or during DRAIN when no frame follows.
            frame_done_d = out_valid_d && (cur_branch == 2'd3) &&
                           (cur_idx == IW'(DEPTH - 1)) &&
                           ((state_q == StDrain) || first_grp);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            bf_en      <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            phase      <= '0;
            idx        <= '0;
            out_branch <= '0;
            tw_addr    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready   <= (state_d != StDrain);
            busy       <= (state_d != StIdle);
            wr_en      <= wr_en_d;
            bf_en      <= bf_en_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
            if (flush) begin
                phase      <= '0;
                idx        <= '0;
                out_branch <= '0;
                tw_addr    <= '0;
            end else if (step) begin
                phase      <= cur_phase;
                idx        <= cur_idx;
                out_branch <= cur_branch;
                tw_addr    <= cur_tw;
            end
        end
    end

endmodule
